spi_adc_scanner: RTL and testbench
==================================

# spi_adc_scanner

Parametrised SPI front end for one or more serial ADCs (ADCS7476-style, 16-bit frame with leading zeros) that share `cs`/`sck` and each drive their own `sdo` line. It generates the SPI framing from the system clock, deserialises every channel in parallel, and publishes the samples with a one-cycle `valid` strobe. A per-channel hysteretic threshold comparator drives the LED/alarm logic. It supports single-shot and continuous acquisition.

## Interface
- `CHANNELS`, 2: number of ADCs sharing `cs`/`sck`; range 1..8.
- `DATA_W`, 12: sample width; the low `DATA_W` bits of each frame are kept.
- `FRAME_W`, 16: sck cycles per frame; must be ≥ `DATA_W`; the leading `FRAME_W-DATA_W` bits are discarded.
- `DIV`, 2: clk cycles per sck half-period; ≥ 1.
- `GAP`, 4: clk cycles `cs` stays high between frames (ADC quiet time); ≥ 1.
- `clk` in 1: system clock. All logic runs on its rising edge; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mode` in 1: 0 = single-shot, 1 = continuous.
- `start` in 1: single-shot trigger, sampled only in IDLE.
- `threshold` in `DATA_W`: comparator set level.
- `hyst` in `DATA_W`: hysteresis width below `threshold`.
- `sdo` in `CHANNELS`: serial data, bit i from ADC i, MSB first.
- `cs` out 1: chip select, active-low.
- `sck` out 1: serial clock, idles high.
- `data` out `CHANNELS*DATA_W`: channel i at `[i*DATA_W +: DATA_W]`.
- `valid` out 1: one-cycle pulse when `data` updates.
- `above` out `CHANNELS`: hysteretic comparator flags.
- `busy` out 1: high from the first `cs`-low cycle through the last QUIET cycle.

## Operation
- Reset values while `rst_n`=0: `cs`=1, `sck`=1, `data`=0, `valid`=0, `above`=0, `busy`=0, state IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately. No `valid` is issued and `data`/`above` clear.
- The FSM has three states: IDLE, FRAME, QUIET.
- IDLE -> FRAME when `mode`=1 or `start`=1.
- FRAME -> QUIET after the `FRAME_W`-th sck rising edge.
- QUIET -> FRAME after `GAP` cycles if `mode`=1; otherwise QUIET -> IDLE.
- `start` is ignored outside IDLE. It is not queued.
- In FRAME, a divider counts `DIV` clk cycles per sck half-period. `sck` falls first.
- ADCs shift on sck falling edges. The block samples all `sdo` bits on the clk edge at which it drives `sck` high, and shifts them into per-channel `FRAME_W`-bit shift registers.
- On entering QUIET, the low `DATA_W` bits of every shift register load into `data`, and `valid` pulses.
- Comparator update, per channel, on the same cycle as the load, using the new sample s:
  - set `above[i]` if s > `threshold`;
  - clear it if s < `threshold - hyst`;
  - otherwise hold.
- The subtraction is done in `DATA_W+1` bits and saturates at 0, so clearing is impossible when `hyst` ≥ `threshold`.
- Setting is impossible when `threshold` = all-ones.
- Clearing `mode` mid-frame does not truncate the frame: it completes, then QUIET, then IDLE.

## Timing
- Cycle 0 is the first cycle with `cs`=0. It is the cycle after IDLE sees `start`/`mode`, or the cycle after the last QUIET cycle.
- `sck` falls at cycles `DIV*(2k-1)` and rises at cycles `2*DIV*k`, for k = 1..`FRAME_W`.
- The k-th rising edge captures frame bit `FRAME_W-k`.
- `cs`, `valid` and `data`: `cs` returns high at cycle `2*DIV*FRAME_W+1`. `valid`=1 and the new `data`/`above` appear on that same cycle.
- `cs` is low for exactly `2*DIV*FRAME_W+1` cycles. `sck`=1 whenever `cs`=1.
- QUIET occupies `GAP` cycles, starting with the `cs`-rise cycle.
- In continuous mode, `cs` is high for exactly `GAP` cycles between frames. Frame period = `2*DIV*FRAME_W+1+GAP` cycles.
- `busy`=1 from cycle 0 through the last QUIET cycle.

## Test plan
All scenarios use `CHANNELS`=2, `DATA_W`=12, `FRAME_W`=16, `DIV`=2, `GAP`=4.

1. Reset: hold `rst_n`=0, toggle `sdo`/`start` -> `cs`=1, `sck`=1, `data`=0, `valid`=0, `above`=0, `busy`=0.
2. Single-shot: pulse `start`; ADC models serialise 16'h0ABC (ch0) and 16'h0123 (ch1) MSB first -> 16 sck falls, `cs` low 65 cycles, one `valid` at cycle 65, `data`=24'h123ABC, then IDLE with `busy`=0 after 4 QUIET cycles.
3. Hysteresis: `threshold`=12'h800, `hyst`=12'h010; ch0 samples 7FF, 801, 7F5, 7EF, 7F0 -> `above[0]` = 0, 1, 1, 0, 0.
4. Continuous: `mode`=1 -> back-to-back frames with period 69 cycles and `cs` high exactly 4 cycles each gap; drop `mode` mid-frame -> that frame completes with `valid`, then IDLE, no further `cs` fall.
5. Abort/ignore: `start` pulsed while `busy` -> no extra frame; `rst_n` low at cycle 30 of a frame -> `cs`/`sck` high same cycle, no `valid`, `data` cleared.
6. Saturation: `threshold`=12'h005, `hyst`=12'h010, samples 006 then 000 -> `above[0]` stays 1; `threshold`=12'hFFF, sample FFF -> `above` stays 0.

Source files
------------

// File: rtl/spi_adc_scanner_if.sv
// Bus bundle between the SPI ADC scanner and its host/ADC side.
// The slave modport is the scanner's view; the master modport is the view of the logic driving it.
interface spi_adc_scanner_if #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 12
);
    logic                         mode;
    logic                         start;
    logic [DATA_W-1:0]            threshold;
    logic [DATA_W-1:0]            hyst;
    logic [CHANNELS-1:0]          sdo;
    logic                         cs;
    logic                         sck;
    logic [CHANNELS*DATA_W-1:0]   data;
    logic                         valid;
    logic [CHANNELS-1:0]          above;
    logic                         busy;

    modport master (
        output mode, start, threshold, hyst, sdo,
        input  cs, sck, data, valid, above, busy
    );

    modport slave (
        input  mode, start, threshold, hyst, sdo,
        output cs, sck, data, valid, above, busy
    );
endinterface

// File: rtl/spi_adc_scanner.sv
// SPI front end for CHANNELS serial ADCs sharing cs/sck: frames, deserialises and
// publishes samples with a valid strobe plus a hysteretic threshold flag per channel.
//
// state | meaning
// IDLE  | cs high, waiting for start (single-shot) or mode (continuous)
// FRAME | cs low, sck toggling every DIV cycles, capturing sdo on sck rise
// QUIET | cs high for GAP cycles; first cycle loads data/above and pulses valid
module spi_adc_scanner #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 12,
    parameter int FRAME_W  = 16,
    parameter int DIV      = 2,
    parameter int GAP      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_adc_scanner_if.slave  adc_bus
);

    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int RISE_W = $clog2(FRAME_W + 1);
    localparam int GAP_W  = $clog2(GAP + 1);

    typedef enum logic [1:0] {IDLE, FRAME, QUIET} state_t;

    state_t                          state_q, state_d;
    logic [DIV_W-1:0]                div_q, div_d;
    logic [RISE_W-1:0]               rise_q, rise_d;
    logic [GAP_W-1:0]                gap_q, gap_d;
    logic                            sck_q, sck_d;
    logic                            valid_q, valid_d;
    logic [CHANNELS-1:0][FRAME_W-1:0] shift_q, shift_d;
    logic [CHANNELS*DATA_W-1:0]      data_q, data_d;
    logic [CHANNELS-1:0]             above_q, above_d;

    logic [DATA_W:0]                 clr_diff;
    logic [DATA_W-1:0]               clr_level;
    logic [DATA_W-1:0]               sample;

    // Clear level saturates at zero, which makes clearing impossible when hyst >= threshold.
    assign clr_diff  = {1'b0, adc_bus.threshold} - {1'b0, adc_bus.hyst};
    assign clr_level = clr_diff[DATA_W] ? '0 : clr_diff[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            rise_q  <= '0;
            gap_q   <= '0;
            sck_q   <= 1'b1;
            valid_q <= 1'b0;
            shift_q <= '0;
            data_q  <= '0;
            above_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rise_q  <= rise_d;
            gap_q   <= gap_d;
            sck_q   <= sck_d;
            valid_q <= valid_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            above_q <= above_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rise_d  = rise_q;
        gap_d   = gap_q;
        sck_d   = sck_q;
        valid_d = 1'b0;
        shift_d = shift_q;
        data_d  = data_q;
        above_d = above_q;
        sample  = '0;

        case (state_q)
            IDLE: begin
                sck_d = 1'b1;
                if (adc_bus.mode || adc_bus.start) begin
                    state_d = FRAME;
                    div_d   = DIV_W'(DIV - 1);
                    rise_d  = RISE_W'(FRAME_W);
                end
            end

            FRAME: begin
                if (rise_q == '0) begin
                    state_d = QUIET;
                    gap_d   = GAP_W'(GAP - 1);
                    sck_d   = 1'b1;
                    valid_d = 1'b1;
                    for (int ch = 0; ch < CHANNELS; ch++) begin
                        sample = shift_q[ch][DATA_W-1:0];
                        data_d[ch*DATA_W +: DATA_W] = sample;
                        if (sample > adc_bus.threshold) begin
                            above_d[ch] = 1'b1;
                        end else if (sample < clr_level) begin
                            above_d[ch] = 1'b0;
                        end
                    end
                end else if (div_q == '0) begin
                    div_d = DIV_W'(DIV - 1);
                    sck_d = ~sck_q;
                    // sdo is captured on the same clk edge that drives sck high.
                    if (!sck_q) begin
                        rise_d = rise_q - RISE_W'(1);
                        for (int ch = 0; ch < CHANNELS; ch++) begin
                            shift_d[ch] = (shift_q[ch] << 1) | FRAME_W'(adc_bus.sdo[ch]);
                        end
                    end
                end else begin
                    div_d = div_q - DIV_W'(1);
                end
            end

            QUIET: begin
                sck_d = 1'b1;
                if (gap_q == '0) begin
                    if (adc_bus.mode) begin
                        state_d = FRAME;
                        div_d   = DIV_W'(DIV - 1);
                        rise_d  = RISE_W'(FRAME_W);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                sck_d   = 1'b1;
            end
        endcase
    end

    assign adc_bus.cs    = (state_q != FRAME);
    assign adc_bus.sck   = sck_q;
    assign adc_bus.data  = data_q;
    assign adc_bus.valid = valid_q;
    assign adc_bus.above = above_q;
    assign adc_bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Bench for spi_adc_scanner: behavioural ADC models feed sdo, expected samples
// are queued when a conversion is launched and compared when valid pulses.
module tb_spi_adc_scanner;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_adc_scanner_if #(.CHANNELS(2), .DATA_W(12)) bus ();

    spi_adc_scanner #(
        .CHANNELS (2),
        .DATA_W   (12),
        .FRAME_W  (16),
        .DIV      (2),
        .GAP      (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .adc_bus (bus)
    );

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  above;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt  = 0;
    int   check_cnt = 0;

    // ADC models: each sck fall shifts out the next bit, MSB first.
    logic [15:0] word0, word1;
    logic [1:0]  adc_sdo, sdo_ovr;
    logic        sdo_ovr_en;
    int          nfall;

    assign bus.sdo = sdo_ovr_en ? sdo_ovr : adc_sdo;

    always @(negedge bus.cs) nfall = 0;
    always @(negedge bus.sck) begin
        if (bus.cs === 1'b0) begin
            if (nfall < 16) begin
                adc_sdo[0] = word0[15-nfall];
                adc_sdo[1] = word1[15-nfall];
            end
            nfall++;
        end
    end

    // Bus monitor: frame edges, lengths and valid strobes in clk cycles.
    int cyc = 0;
    int fall_cnt = 0, cs_fall_cyc = 0, prev_fall_cyc = 0, cs_rise_cyc = 0;
    int gap_len = 0, low_len = 0, sck_falls = 0, valid_cnt = 0, valid_cyc = 0;
    logic prev_cs = 1'b1, prev_sck = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_cs === 1'b1 && bus.cs === 1'b0) begin
            prev_fall_cyc = cs_fall_cyc;
            cs_fall_cyc   = cyc;
            gap_len       = cyc - cs_rise_cyc;
            fall_cnt++;
            sck_falls = 0;
        end
        if (prev_cs === 1'b0 && bus.cs === 1'b1) begin
            cs_rise_cyc = cyc;
            low_len     = cyc - cs_fall_cyc;
        end
        if (prev_sck === 1'b1 && bus.sck === 1'b0) sck_falls++;
        if (bus.valid === 1'b1) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        prev_cs  = bus.cs;
        prev_sck = bus.sck;
    end

    task automatic push_exp(input logic [15:0] w0, input logic [15:0] w1, input logic [1:0] ab);
        exp_t e;
        word0   = w0;
        word1   = w1;
        e.data  = {w1[11:0], w0[11:0]};
        e.above = ab;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start();
        for (int i = 0; i < 200 && bus.busy !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic get_result(output bit ok, output exp_t e);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sdo_ovr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sdo_ovr   = 2'($urandom_range(0, 3));
            bus.start = ~bus.start;
        end
        #1;
        check_cnt++; if (bus.cs !== 1'b1)   $display("FAIL reset_cs: got %b expected 1", bus.cs); else pass_cnt++;
        check_cnt++; if (bus.sck !== 1'b1)  $display("FAIL reset_sck: got %b expected 1", bus.sck); else pass_cnt++;
        check_cnt++; if (bus.data !== 24'h0) $display("FAIL reset_data: got %h expected 000000", bus.data); else pass_cnt++;
        check_cnt++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid); else pass_cnt++;
        check_cnt++; if (bus.above !== 2'b00) $display("FAIL reset_above: got %b expected 00", bus.above); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
        bus.start  = 1'b0;
        sdo_ovr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bit   ok;
        exp_t e;
        int   vc;
        bus.threshold = 12'hFFF;
        bus.hyst      = 12'h000;
        push_exp(16'h0ABC, 16'h0123, 2'b00);
        vc = valid_cnt;
        pulse_start();
        get_result(ok, e);
        check_cnt++; if (!ok) $display("FAIL single_timeout: got no valid expected valid"); else pass_cnt++;
        check_cnt++; if (bus.data !== e.data) $display("FAIL single_data: got %h expected %h", bus.data, e.data); else pass_cnt++;
        check_cnt++; if (bus.data !== 24'h123ABC) $display("FAIL single_data_const: got %h expected 123abc", bus.data); else pass_cnt++;
        check_cnt++; if (bus.above !== e.above) $display("FAIL single_above: got %b expected %b", bus.above, e.above); else pass_cnt++;
        check_cnt++; if (low_len != 65) $display("FAIL single_cs_low: got %0d expected 65", low_len); else pass_cnt++;
        check_cnt++; if (sck_falls != 16) $display("FAIL single_sck_falls: got %0d expected 16", sck_falls); else pass_cnt++;
        check_cnt++; if (valid_cyc - cs_fall_cyc != 65) $display("FAIL single_valid_cycle: got %0d expected 65", valid_cyc - cs_fall_cyc); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (bus.valid !== 1'b0) $display("FAIL single_valid_width: got %b expected 0", bus.valid); else pass_cnt++;
        repeat (2) @(negedge clk);
        check_cnt++; if (bus.busy !== 1'b1) $display("FAIL single_busy_last_quiet: got %b expected 1", bus.busy); else pass_cnt++;
        @(negedge clk);
        check_cnt++; if (bus.busy !== 1'b0 || bus.cs !== 1'b1) $display("FAIL single_idle: got busy=%b cs=%b expected busy=0 cs=1", bus.busy, bus.cs); else pass_cnt++;
        check_cnt++; if (valid_cnt - vc != 1) $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - vc); else pass_cnt++;
    endtask

    task automatic test_hysteresis();
        logic [11:0] smp[5] = '{12'h7FF, 12'h801, 12'h7F5, 12'h7EF, 12'h7F0};
        logic        ab[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit   ok;
        exp_t e;
        bus.threshold = 12'h800;
        bus.hyst      = 12'h010;
        for (int i = 0; i < 5; i++) begin
            push_exp({4'h0, smp[i]}, 16'h0000, {1'b0, ab[i]});
            pulse_start();
            get_result(ok, e);
            check_cnt++; if (!ok || bus.data !== e.data) $display("FAIL hyst_data_%0d: got %h expected %h", i, bus.data, e.data); else pass_cnt++;
            check_cnt++; if (bus.above !== e.above) $display("FAIL hyst_above_%0d: got %b expected %b", i, bus.above, e.above); else pass_cnt++;
        end
    endtask

    task automatic test_continuous();
        bit   ok;
        exp_t e;
        int   fc, vc;
        bus.threshold = 12'h800;
        bus.hyst      = 12'h010;
        for (int i = 0; i < 3; i++) push_exp(16'h0555, 16'h0AAA, 2'b10);
        for (int i = 0; i < 200 && bus.busy !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        bus.mode = 1'b1;
        get_result(ok, e);
        check_cnt++; if (!ok || bus.data !== e.data) $display("FAIL cont_data_1: got %h expected %h", bus.data, e.data); else pass_cnt++;
        get_result(ok, e);
        check_cnt++; if (!ok || bus.data !== e.data) $display("FAIL cont_data_2: got %h expected %h", bus.data, e.data); else pass_cnt++;
        check_cnt++; if (bus.above !== e.above) $display("FAIL cont_above: got %b expected %b", bus.above, e.above); else pass_cnt++;
        check_cnt++; if (cs_fall_cyc - prev_fall_cyc != 69) $display("FAIL cont_period: got %0d expected 69", cs_fall_cyc - prev_fall_cyc); else pass_cnt++;
        check_cnt++; if (gap_len != 4) $display("FAIL cont_gap: got %0d expected 4", gap_len); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cs === 1'b0) break;
        end
        repeat (20) @(negedge clk);
        bus.mode = 1'b0;
        get_result(ok, e);
        check_cnt++; if (!ok || bus.data !== e.data) $display("FAIL cont_last_frame: got %h expected %h", bus.data, e.data); else pass_cnt++;
        check_cnt++; if (low_len != 65) $display("FAIL cont_last_cs_low: got %0d expected 65", low_len); else pass_cnt++;
        fc = fall_cnt;
        vc = valid_cnt;
        repeat (150) @(negedge clk);
        check_cnt++; if (fall_cnt != fc) $display("FAIL cont_stop: got %0d extra cs falls expected 0", fall_cnt - fc); else pass_cnt++;
        check_cnt++; if (bus.busy !== 1'b0) $display("FAIL cont_idle_busy: got %b expected 0", bus.busy); else pass_cnt++;
        check_cnt++; if (valid_cnt != vc) $display("FAIL cont_extra_valid: got %0d expected 0", valid_cnt - vc); else pass_cnt++;
    endtask

    task automatic test_abort();
        bit   ok;
        exp_t e;
        int   fc, vc;
        bus.threshold = 12'hFFF;
        bus.hyst      = 12'h000;
        push_exp(16'h0456, 16'h0789, 2'b00);
        fc = fall_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        check_cnt++; if (bus.busy !== 1'b1) $display("FAIL abort_busy: got %b expected 1", bus.busy); else pass_cnt++;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        get_result(ok, e);
        check_cnt++; if (!ok || bus.data !== e.data) $display("FAIL ignore_data: got %h expected %h", bus.data, e.data); else pass_cnt++;
        check_cnt++; if (bus.above !== e.above) $display("FAIL ignore_above: got %b expected %b", bus.above, e.above); else pass_cnt++;
        repeat (150) @(negedge clk);
        check_cnt++; if (fall_cnt != fc + 1) $display("FAIL ignore_start: got %0d frames expected 1", fall_cnt - fc); else pass_cnt++;

        word0 = 16'h0FFF;
        word1 = 16'h0FFF;
        vc = valid_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_cnt++; if (bus.cs !== 1'b1 || bus.sck !== 1'b1) $display("FAIL abort_pins: got cs=%b sck=%b expected cs=1 sck=1", bus.cs, bus.sck); else pass_cnt++;
        check_cnt++; if (bus.data !== 24'h0) $display("FAIL abort_data: got %h expected 000000", bus.data); else pass_cnt++;
        check_cnt++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL abort_state: got valid=%b busy=%b expected 0 0", bus.valid, bus.busy); else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check_cnt++; if (valid_cnt != vc) $display("FAIL abort_no_valid: got %0d valids expected 0", valid_cnt - vc); else pass_cnt++;
        check_cnt++; if (sb_q.size() != 0) $display("FAIL abort_scoreboard: got %0d pending expected 0", sb_q.size()); else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [11:0] thr[4] = '{12'h005, 12'h005, 12'hFFF, 12'hFFF};
        logic [11:0] hys[4] = '{12'h010, 12'h010, 12'h000, 12'h000};
        logic [11:0] smp[4] = '{12'h006, 12'h000, 12'h000, 12'hFFF};
        logic [1:0]  ab[4]  = '{2'b11, 2'b11, 2'b00, 2'b00};
        bit   ok;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 200 && bus.busy !== 1'b0; j++) @(negedge clk);
            bus.threshold = thr[i];
            bus.hyst      = hys[i];
            push_exp({4'h0, smp[i]}, {4'h0, smp[i]}, ab[i]);
            pulse_start();
            get_result(ok, e);
            check_cnt++; if (!ok || bus.data !== e.data) $display("FAIL sat_data_%0d: got %h expected %h", i, bus.data, e.data); else pass_cnt++;
            check_cnt++; if (bus.above !== e.above) $display("FAIL sat_above_%0d: got %b expected %b", i, bus.above, e.above); else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b1;
        bus.mode      = 1'b0;
        bus.start     = 1'b0;
        bus.threshold = 12'hFFF;
        bus.hyst      = 12'h000;
        word0         = 16'h0000;
        word1         = 16'h0000;
        adc_sdo       = 2'b00;
        sdo_ovr       = 2'b00;
        sdo_ovr_en    = 1'b0;
        #1;
        test_reset();
        test_single();
        test_hysteresis();
        test_continuous();
        test_abort();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
